// File: rtl/icache_if.sv
// Fetch-side and refill-side signals of the instruction cache.
// slave = the cache, master = CPU fetch stage plus backing memory.
interface icache_if;
  logic [31:0] cpu_addr;
  logic        cpu_req;
  logic [31:0] cpu_data;
  logic        stall;
  logic        flush;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_ready;
  logic [31:0] mem_data;

  modport slave (
    input  cpu_addr, cpu_req, flush, mem_ready, mem_data,
    output cpu_data, stall, mem_addr, mem_req
  );

  modport master (
    output cpu_addr, cpu_req, flush, mem_ready, mem_data,
    input  cpu_data, stall, mem_addr, mem_req
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with word-serial line refill.
// Define ICACHE_STATS_EN to add hit_count / miss_count outputs.
module icache #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input logic clk,
  input logic reset,
  icache_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OFFW = $clog2(WORDS);
  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = 32 - IDXW - OFFW - 2;
  localparam logic [OFFW-1:0] LAST = OFFW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [OFFW-1:0] cnt_q, cnt_d;
  logic [TAGW-1:0] tlat_q, tlat_d;
  logic [IDXW-1:0] ilat_q, ilat_d;
  logic            pend_q, pend_d;
  logic [LINES-1:0] valid_q, valid_d;

  logic [TAGW-1:0] tag_q  [LINES];
  logic [31:0]     data_q [LINES][WORDS];

  logic [OFFW-1:0] off;
  logic [IDXW-1:0] idx;
  logic [TAGW-1:0] tag;
  logic            hit;
  logic            fill_we;
  logic            stall_c;
  logic            mreq_c;
  logic [31:0]     maddr_c;
  logic [31:0]     data_c;
  logic            unused_lsb;

  assign off = bus.cpu_addr[OFFW+1:2];
  assign idx = bus.cpu_addr[IDXW+OFFW+1:OFFW+2];
  assign tag = bus.cpu_addr[31:IDXW+OFFW+2];
  assign unused_lsb = ^bus.cpu_addr[1:0];

  assign hit = (state_q == IDLE) && valid_q[idx] && (tag_q[idx] == tag);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tlat_d  = tlat_q;
    ilat_d  = ilat_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    fill_we = 1'b0;
    stall_c = 1'b0;
    mreq_c  = 1'b0;
    maddr_c = '0;
    data_c  = '0;
    unique case (1'b1)
      (state_q == IDLE): begin
        // lookup this cycle still sees the pre-flush valid bits
        if (bus.flush) valid_d = '0;
        if (bus.cpu_req) begin
          if (hit) begin
            data_c = data_q[idx][off];
          end else begin
            stall_c = 1'b1;
            tlat_d  = tag;
            ilat_d  = idx;
            cnt_d   = '0;
            state_d = REFILL;
          end
        end
      end
      (state_q == REFILL): begin
        stall_c = 1'b1;
        mreq_c  = 1'b1;
        maddr_c = {tlat_q, ilat_q, cnt_q, 2'b00};
        if (bus.flush) pend_d = 1'b1;
        if (bus.mem_ready) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + OFFW'(1);
          if (cnt_q == LAST) begin
            valid_d[ilat_q] = 1'b1;
            state_d = DONE;
          end
        end
      end
      (state_q == DONE): begin
        stall_c = 1'b1;
        state_d = IDLE;
        // deferred flush also kills the line just filled
        if (bus.flush || pend_q) begin
          valid_d = '0;
          pend_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.stall    = reset & stall_c;
  assign bus.mem_req  = mreq_c;
  assign bus.mem_addr = maddr_c;
  assign bus.cpu_data = data_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tlat_q  <= '0;
      ilat_q  <= '0;
      pend_q  <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tlat_q  <= tlat_d;
      ilat_q  <= ilat_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[ilat_q][cnt_q] <= bus.mem_data;
      if (cnt_q == LAST) tag_q[ilat_q] <= tlat_q;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_q, miss_q;
  logic        st_hit, st_miss;

  assign st_hit  = bus.cpu_req && hit;
  assign st_miss = (state_q == IDLE) && bus.cpu_req && !hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (st_hit)  hit_q  <= hit_q + 32'd1;
      if (st_miss) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the CPU fetch stage (PC / instruction-memory port) and the backing instruction memory. A fetch address is looked up combinationally. On a hit the instruction is returned in the same cycle. On a miss the block raises `stall`, which the CPU ANDs into the PC and IF/ID write enables. It then refills the whole line from backing memory word by word over a req/ready handshake, and releases the stall once the line is valid.

## Interface
Parameters:
- `LINES`, 16: number of cache lines; power of two, ≥2.
- `WORDS`, 4: 32-bit words per line; power of two, ≥2.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `cpu_addr`, in, 32: fetch byte address; bits [1:0] ignored.
- `cpu_req`, in, 1: fetch valid this cycle.
- `cpu_data`, out, 32: instruction; valid when `cpu_req & !stall`.
- `stall`, out, 1: freeze PC and IF/ID.
- `flush`, in, 1: invalidate all lines (one-cycle pulse).
- `mem_addr`, out, 32: word-aligned refill address.
- `mem_req`, out, 1: refill request.
- `mem_ready`, in, 1: backing memory has `mem_data` valid for the current `mem_addr`.
- `mem_data`, in, 32: refill word.

## Operation
- Address split: offset = `cpu_addr[$clog2(WORDS)+1:2]`, index = next `$clog2(LINES)` bits, tag = remaining upper bits.
- Storage per line:
  - valid bit;
  - tag;
  - `WORDS` data words.
- Hit = `state==IDLE & valid[index] & tag match`.
- FSM states:
  - IDLE:
    - `cpu_req & hit`: `cpu_data` = stored word, `stall`=0.
    - `cpu_req & !hit`: `stall`=1; latch tag/index, clear word counter, go to REFILL.
  - REFILL:
    - `mem_req`=1, `mem_addr` = {latched tag, index, counter, 2'b00}, held stable until `mem_ready` is sampled high.
    - On each sampled `mem_ready`: write `mem_data` into word[counter] and increment the counter.
    - On the last word: write the tag, set valid, go to DONE.
  - DONE:
    - `stall`=1, `mem_req`=0.
    - Next edge goes to IDLE, where the retried fetch hits.
- Refill order is always word 0 to `WORDS-1`. There is no critical-word-first.
- Only one refill is outstanding at a time. `cpu_addr` changes while `stall`=1 are ignored; the latched address governs the refill.
- `flush`:
  - In IDLE: all valid bits clear on the next edge; that cycle's lookup still uses the pre-flush state.
  - Outside IDLE: set a pending flag. Apply it (including invalidating the just-refilled line) on entry to IDLE, then perform the lookup.
- `cpu_req`=0: no state change, `stall`=0 in IDLE.

## Timing
- Reset values:
  - state IDLE;
  - all valid bits 0;
  - word counter 0;
  - pending flush 0;
  - `mem_req` 0;
  - `mem_addr` 0;
  - `stall` 0;
  - `cpu_data` 0.
- Reset is asynchronous: asserting it mid-refill drops `mem_req` immediately, and a partially written line stays invalid.
- Hit latency: 0 cycles (combinational from `cpu_addr`).
- Miss penalty: `stall` is high for 1 (IDLE detect) + Σ(cycles per word until `mem_ready`) + 1 (DONE) cycles.
  - Example: with `WORDS`=4 and `mem_ready` tied high, `stall` is high for 6 cycles.
- `stall` is combinational in IDLE (miss detect) and registered-state-driven in REFILL/DONE.
- `mem_ready` is ignored while `mem_req`=0.

## Configuration
- `ICACHE_STATS_EN` defined:
  - Adds outputs `hit_count` [31:0] and `miss_count` [31:0], both reset to 0.
  - `hit_count` increments on each IDLE cycle with `cpu_req & hit`.
  - `miss_count` increments on each IDLE→REFILL transition.
  - Both counters wrap at 2³²−1 → 0.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Cold miss:
  - Stimulus: `cpu_addr`=0x0000_0040, `mem_ready` high 2 cycles after each request, memory returns 0xA0+word.
  - Required: `mem_addr` steps 0x40, 0x44, 0x48, 0x4C; `stall` falls after DONE; `cpu_data`=0xA0.
- Hit after refill:
  - Stimulus: fetch 0x44, 0x48, 0x4C in consecutive cycles.
  - Required: `stall`=0, `cpu_data`=0xA1, 0xA2, 0xA3, `mem_req` never asserted.
- Conflict eviction:
  - Stimulus: with `LINES`=16 and `WORDS`=4, fetch 0x40, then 0x140 (same index, different tag), then 0x40.
  - Required: three refills, each returning the correct data.
- Flush:
  - Stimulus: pulse `flush` in IDLE after line 0x40 is valid, then fetch 0x40.
  - Required: a miss and a refill.
  - Stimulus: pulse `flush` during REFILL.
  - Required: the refilled line is invalid on return to IDLE, and an immediate refetch misses again.
- Reset mid-refill:
  - Stimulus: assert `reset`=0 after word 1 is captured.
  - Required: `mem_req`=0 and `stall`=0 immediately; after release, a fetch of the same address misses.
- Stats (`ICACHE_STATS_EN`):
  - Stimulus: the cold-miss plus three-hit sequence.
  - Required: `miss_count`=1, `hit_count`=4 (the retried fetch counts as a hit).
